// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential instruction prefetcher in front of the IF/ID register.
// Issues word-aligned fetches over a req/gnt/rvalid memory port. Returned words
// are buffered with their PC in a DEPTH-entry FIFO and presented to the core
// through valid/ready. A redirect flushes the FIFO and marks every in-flight
// response as stale.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_redirect, i_redirect_pc         taken-branch pulse and new fetch PC
//   o_mem_req, o_mem_addr, i_mem_gnt  fetch request channel
//   i_mem_rvalid, i_mem_rdata         in-order response channel
//   o_instr_valid, o_instr, o_instr_pc, i_instr_ready  core-side handshake
module ifu_prefetch #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  output logic                   o_mem_req,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_gnt,
  input  logic                   i_mem_rvalid,
  input  logic [INSTR_WIDTH-1:0] i_mem_rdata,
  output logic                   o_instr_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_instr_pc,
  input  logic                   i_instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0]  fetch_pc, resp_pc, redir_pc;
  logic [INSTR_WIDTH-1:0] fifo_instr [DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_pc    [DEPTH];
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          count, outstanding, discard;
  logic [CW:0]            credit;
  logic                   accept, resp, push, pop;

  // Reserving a FIFO slot for every outstanding request is what keeps the
  // FIFO from overflowing; no separate full check is needed on push.
  assign credit        = {1'b0, count} + {1'b0, outstanding};
  assign o_mem_req     = !i_rst && !i_redirect && (credit < (CW+1)'(DEPTH));
  assign o_mem_addr    = fetch_pc;
  assign accept        = o_mem_req && i_mem_gnt;
  // A response with nothing outstanding is a protocol violation and ignored;
  // this also swallows stray responses right after reset.
  assign resp          = i_mem_rvalid && (outstanding != '0);
  assign push          = resp && (discard == '0) && !i_redirect;
  assign o_instr_valid = (count != '0) && !i_redirect;
  assign pop           = o_instr_valid && i_instr_ready;
  assign o_instr       = fifo_instr[rd_ptr];
  assign o_instr_pc    = fifo_pc[rd_ptr];
  // Mask the byte offset rather than slicing so every input bit is consumed.
  assign redir_pc      = i_redirect_pc & ~ADDR_WIDTH'(3);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      // Storage is cleared so the head outputs read zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(resp);
      if (i_redirect) begin
        fetch_pc <= redir_pc;
        resp_pc  <= redir_pc;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        // Everything granted before this cycle is stale; a response landing
        // in this very cycle is already dropped, so it is not counted again.
        discard  <= outstanding - CW'(resp);
      end else begin
        if (accept) fetch_pc <= fetch_pc + STEP;
        if (resp && (discard != '0)) discard <= discard - CW'(1);
        if (push) begin
          fifo_instr[wr_ptr] <= i_mem_rdata;
          fifo_pc[wr_ptr]    <= resp_pc;
          wr_ptr             <= wr_ptr + PW'(1);
          resp_pc            <= resp_pc + STEP;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
